// File: rtl/zulu_rx_rate_meter.sv
// zulu_rx_rate_meter
//   Passive per-channel RX statistics for CHAN_COUNT AXI-stream MAC buses.
//   Bytes, frames and errored frames are accumulated over a WINDOW_CYCLES
//   window, then published as a per-channel snapshot with a one-cycle
//   stat_valid pulse. Every counter saturates, and saturation is reported
//   through a sticky per-channel stat_ovf flag.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   stat_rst        synchronous clear of timer, accumulators, snapshots, ovf
//   chan_en         per-channel counting enable
//   mon_valid/ready/last/user  observed handshake, tlast and tuser per channel
//   mon_keep        tkeep, channel i at [i*KEEP_W +: KEEP_W]
//   stat_bytes/frames/errs     snapshots, channel i at [i*CNT_W +: CNT_W]
//   stat_valid      one-cycle pulse when the snapshots update
//   stat_ovf        sticky per-channel saturation flag

// Per-channel accumulators and snapshots.
module zulu_rx_rate_lane #(
  parameter int KEEP_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stat_rst_i,
  input  logic              term_i,
  input  logic              en_i,
  input  logic              beat_i,
  input  logic              last_i,
  input  logic              user_i,
  input  logic [KEEP_W-1:0] keep_i,
  output logic [CNT_W-1:0]  bytes_o,
  output logic [CNT_W-1:0]  frames_o,
  output logic [CNT_W-1:0]  errs_o,
  output logic              ovf_o
);
  typedef struct packed {
    logic             ovf;
    logic [CNT_W-1:0] val;
  } sat_t;

  // An add counts as an overflow if it carries out, or if the accumulator
  // is already pinned at all-ones when the add is attempted (even +0).
  function automatic sat_t sat_add(input logic [CNT_W-1:0] a,
                                   input logic [CNT_W-1:0] b,
                                   input logic act);
    logic [CNT_W:0] s;
    sat_t r;
    s     = {1'b0, a} + {1'b0, b};
    r.ovf = act & (s[CNT_W] | (&a));
    r.val = !act ? a : (s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0]);
    return r;
  endfunction

  logic [CNT_W-1:0] byte_q, frm_q, err_q;
  logic [CNT_W-1:0] sbyte_q, sfrm_q, serr_q;
  logic             ovf_q;
  logic [CNT_W-1:0] pop;
  sat_t             byte_d, frm_d, err_d;

  always_comb begin
    pop = '0;
    for (int k = 0; k < KEEP_W; k++) pop = pop + CNT_W'(keep_i[k]);
    byte_d = sat_add(byte_q, pop, beat_i);
    frm_d  = sat_add(frm_q, CNT_W'(1), beat_i & last_i);
    err_d  = sat_add(err_q, CNT_W'(1), beat_i & last_i & user_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q <= '0; frm_q <= '0; err_q <= '0;
      sbyte_q <= '0; sfrm_q <= '0; serr_q <= '0;
      ovf_q <= 1'b0;
    end else if (stat_rst_i) begin
      byte_q <= '0; frm_q <= '0; err_q <= '0;
      sbyte_q <= '0; sfrm_q <= '0; serr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (byte_d.ovf | frm_d.ovf | err_d.ovf) ovf_q <= 1'b1;
      if (term_i) begin
        // Terminal-cycle beats close out with the window; a disabled
        // channel keeps its previous snapshot.
        byte_q <= '0; frm_q <= '0; err_q <= '0;
        if (en_i) begin
          sbyte_q <= byte_d.val;
          sfrm_q  <= frm_d.val;
          serr_q  <= err_d.val;
        end
      end else begin
        byte_q <= byte_d.val;
        frm_q  <= frm_d.val;
        err_q  <= err_d.val;
      end
    end
  end

  assign bytes_o  = sbyte_q;
  assign frames_o = sfrm_q;
  assign errs_o   = serr_q;
  assign ovf_o    = ovf_q;
endmodule

module zulu_rx_rate_meter #(
  parameter int CHAN_COUNT    = 8,
  parameter int DATA_W        = 64,
  parameter int CNT_W         = 32,
  parameter int WINDOW_CYCLES = 156250000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stat_rst,
  input  logic [CHAN_COUNT-1:0]            chan_en,
  input  logic [CHAN_COUNT-1:0]            mon_valid,
  input  logic [CHAN_COUNT-1:0]            mon_ready,
  input  logic [CHAN_COUNT-1:0]            mon_last,
  input  logic [CHAN_COUNT-1:0]            mon_user,
  input  logic [CHAN_COUNT*(DATA_W/8)-1:0] mon_keep,
  output logic [CHAN_COUNT*CNT_W-1:0]      stat_bytes,
  output logic [CHAN_COUNT*CNT_W-1:0]      stat_frames,
  output logic [CHAN_COUNT*CNT_W-1:0]      stat_errs,
  output logic                             stat_valid,
  output logic [CHAN_COUNT-1:0]            stat_ovf
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int TW     = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic          term;
  logic          vld_q;

  assign term    = (timer_q == TW'(WINDOW_CYCLES - 1));
  assign timer_d = term ? '0 : timer_q + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      vld_q   <= 1'b0;
    end else if (stat_rst) begin
      timer_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      vld_q   <= term;
    end
  end

  assign stat_valid = vld_q;

  for (genvar i = 0; i < CHAN_COUNT; i++) begin : g_lane
    zulu_rx_rate_lane #(.KEEP_W(KEEP_W), .CNT_W(CNT_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .stat_rst_i(stat_rst),
      .term_i    (term),
      .en_i      (chan_en[i]),
      .beat_i    (mon_valid[i] & mon_ready[i] & chan_en[i]),
      .last_i    (mon_last[i]),
      .user_i    (mon_user[i]),
      .keep_i    (mon_keep[i*KEEP_W +: KEEP_W]),
      .bytes_o   (stat_bytes[i*CNT_W +: CNT_W]),
      .frames_o  (stat_frames[i*CNT_W +: CNT_W]),
      .errs_o    (stat_errs[i*CNT_W +: CNT_W]),
      .ovf_o     (stat_ovf[i])
    );
  end
endmodule

// File: tb/tb_zulu_rx_rate_meter.sv
// Directed bench for zulu_rx_rate_meter. u_dut: 2 channels, 16-cycle window,
// 8-bit counters. u_sat: 64-cycle window so one window can carry 40 beats
// for the saturation case; it has its own traffic inputs.
module tb_zulu_rx_rate_meter;
  logic        clk = 1'b0, rst_n = 1'b0, stat_rst = 1'b0;
  logic [1:0]  chan_en = 2'b11, mon_valid = '0, mon_ready = 2'b11;
  logic [1:0]  mon_last = '0, mon_user = '0;
  logic [15:0] mon_keep = '0;
  logic [15:0] stat_bytes, stat_frames, stat_errs;
  logic        stat_valid;
  logic [1:0]  stat_ovf;

  logic [1:0]  s_en = 2'b11, s_valid = '0, s_ready = 2'b11, s_zero = '0;
  logic [15:0] s_keep = '0;
  logic [15:0] s_bytes, s_frames, s_errs;
  logic        s_vld;
  logic [1:0]  s_ovf;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  zulu_rx_rate_meter #(.CHAN_COUNT(2), .DATA_W(64), .CNT_W(8), .WINDOW_CYCLES(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .stat_rst(stat_rst), .chan_en(chan_en),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .mon_user(mon_user), .mon_keep(mon_keep), .stat_bytes(stat_bytes),
    .stat_frames(stat_frames), .stat_errs(stat_errs), .stat_valid(stat_valid),
    .stat_ovf(stat_ovf));

  zulu_rx_rate_meter #(.CHAN_COUNT(2), .DATA_W(64), .CNT_W(8), .WINDOW_CYCLES(64)) u_sat (
    .clk(clk), .rst_n(rst_n), .stat_rst(stat_rst), .chan_en(s_en),
    .mon_valid(s_valid), .mon_ready(s_ready), .mon_last(s_zero),
    .mon_user(s_zero), .mon_keep(s_keep), .stat_bytes(s_bytes),
    .stat_frames(s_frames), .stat_errs(s_errs), .stat_valid(s_vld),
    .stat_ovf(s_ovf));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ch(input string tag, input int ch, input logic [7:0] b,
                        input logic [7:0] f, input logic [7:0] e);
    chk({tag, "_bytes"},  {8'h0, stat_bytes[ch*8 +: 8]},  {8'h0, b});
    chk({tag, "_frames"}, {8'h0, stat_frames[ch*8 +: 8]}, {8'h0, f});
    chk({tag, "_errs"},   {8'h0, stat_errs[ch*8 +: 8]},   {8'h0, e});
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat0(input logic [7:0] k, input logic l, input logic u);
    mon_valid[0] = 1'b1; mon_keep[7:0] = k; mon_last[0] = l; mon_user[0] = u;
  endtask

  task automatic idle();
    mon_valid = '0; mon_keep = '0; mon_last = '0; mon_user = '0;
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_valid", {15'h0, stat_valid}, 16'h0);
    chk("rst_bytes", stat_bytes, 16'h0);
    chk("rst_ovf", {14'h0, stat_ovf}, 16'h0);
    rst_n = 1'b1;

    // 3 frames x 2 beats on ch0: keep FF then 0F
    for (int i = 0; i < 6; i++) begin
      beat0((i % 2 == 0) ? 8'hFF : 8'h0F, (i % 2 == 1), 1'b0);
      tick(1);
    end
    idle();
    tick(9);
    chk("w1_early_valid", {15'h0, stat_valid}, 16'h0);
    tick(1);
    chk("w1_valid", {15'h0, stat_valid}, 16'h1);
    chk_ch("w1_ch0", 0, 8'd36, 8'd3, 8'd0);
    chk_ch("w1_ch1", 1, 8'd0, 8'd0, 8'd0);
    tick(1);
    chk("w1_pulse_end", {15'h0, stat_valid}, 16'h0);
    chk("w1_hold_bytes", {8'h0, stat_bytes[7:0]}, 16'd36);

    // single beat on the terminal cycle belongs to the closing window
    tick(14);
    beat0(8'h01, 1'b1, 1'b1);
    tick(1);
    idle();
    chk("term_valid", {15'h0, stat_valid}, 16'h1);
    chk_ch("term_ch0", 0, 8'd1, 8'd1, 8'd1);
    tick(16);
    chk("next_valid", {15'h0, stat_valid}, 16'h1);
    chk_ch("next_ch0", 0, 8'd0, 8'd0, 8'd0);

    // saturation on u_sat ch1: 40 beats of 8 bytes in one 64-cycle window
    stat_rst = 1'b1; tick(1); stat_rst = 1'b0;
    s_valid[1] = 1'b1; s_keep[15:8] = 8'hFF;
    tick(31);
    chk("sat_ovf_pre", {14'h0, s_ovf}, 16'h0);
    tick(1);
    chk("sat_ovf_set", {14'h0, s_ovf}, 16'h2);
    tick(8);
    s_valid = '0; s_keep = '0;
    tick(23);
    chk("sat_early_valid", {15'h0, s_vld}, 16'h0);
    tick(1);
    chk("sat_valid", {15'h0, s_vld}, 16'h1);
    chk("sat_bytes", s_bytes, 16'hFF00);
    chk("sat_ovf_win", {14'h0, s_ovf}, 16'h2);
    tick(64);
    chk("sat2_valid", {15'h0, s_vld}, 16'h1);
    chk("sat2_bytes", s_bytes, 16'h0);
    chk("sat2_ovf_sticky", {14'h0, s_ovf}, 16'h2);
    stat_rst = 1'b1; tick(1); stat_rst = 1'b0;
    chk("sat_ovf_clr", {14'h0, s_ovf}, 16'h0);

    // stat_rst on the terminal cycle with traffic
    beat0(8'h03, 1'b1, 1'b0);
    tick(1);
    idle();
    tick(15);
    chk("pre_rst_valid", {15'h0, stat_valid}, 16'h1);
    chk_ch("pre_rst_ch0", 0, 8'd2, 8'd1, 8'd0);
    tick(14);
    beat0(8'hFF, 1'b1, 1'b1);
    tick(1);
    stat_rst = 1'b1;
    tick(1);
    stat_rst = 1'b0;
    idle();
    chk("srst_valid", {15'h0, stat_valid}, 16'h0);
    chk_ch("srst_ch0", 0, 8'd0, 8'd0, 8'd0);
    chk("srst_ovf", {14'h0, stat_ovf}, 16'h0);
    tick(15);
    chk("srst_early_valid", {15'h0, stat_valid}, 16'h0);
    tick(1);
    chk("srst_next_valid", {15'h0, stat_valid}, 16'h1);
    chk_ch("srst_next_ch0", 0, 8'd0, 8'd0, 8'd0);

    // ch0 disabled under full traffic, ch1 counting keep 0F
    chan_en = 2'b10;
    mon_valid = 2'b11; mon_keep = 16'h0FFF; mon_last = 2'b11;
    tick(16);
    idle();
    chan_en = 2'b11;
    chk("en_valid", {15'h0, stat_valid}, 16'h1);
    chk_ch("en_ch0", 0, 8'd0, 8'd0, 8'd0);
    chk_ch("en_ch1", 1, 8'd64, 8'd16, 8'd0);

    // backpressure: 10 stalled cycles, then 2 accepted beats
    mon_ready[0] = 1'b0;
    beat0(8'hFF, 1'b0, 1'b0);
    tick(10);
    mon_ready[0] = 1'b1;
    tick(1);
    mon_last[0] = 1'b1;
    tick(1);
    idle();
    tick(4);
    chk("bp_valid", {15'h0, stat_valid}, 16'h1);
    chk_ch("bp_ch0", 0, 8'd16, 8'd1, 8'd0);
    chk_ch("bp_ch1", 1, 8'd0, 8'd0, 8'd0);

    // asynchronous reset mid-window with live accumulators
    beat0(8'hFF, 1'b1, 1'b0);
    tick(5);
    idle();
    #2 rst_n = 1'b0;
    #2;
    chk("arst_bytes", stat_bytes, 16'h0);
    chk("arst_frames", stat_frames, 16'h0);
    chk("arst_errs", stat_errs, 16'h0);
    chk("arst_valid", {15'h0, stat_valid}, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    beat0(8'h3C, 1'b1, 1'b0);
    tick(1);
    idle();
    tick(14);
    chk("arst_early_valid", {15'h0, stat_valid}, 16'h0);
    tick(1);
    chk("arst_next_valid", {15'h0, stat_valid}, 16'h1);
    chk_ch("arst_next_ch0", 0, 8'd4, 8'd1, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/zulu_rx_rate_meter.md
Name: zulu_rx_rate_meter

Overview:
- Parametrised per-channel RX traffic statistics engine for the Zulu data plane.
- Monitors CHAN_COUNT AXI-stream MAC buses without intercepting them.
- Accumulates bytes, frames and errored frames over a fixed measurement window, then publishes a per-channel snapshot.
- Successor to the single fixed-width stat_rx_speed output: generalised in data width, channel count, counter width and window length. Adds frame/error counts, per-channel enable, saturation and a sticky overflow flag.

Parameters:
- CHAN_COUNT, 8, number of monitored channels (1..32).
- DATA_W, 64, monitored data width in bits; multiple of 8.
- KEEP_W, DATA_W/8, keep width; derived, not overridden.
- CNT_W, 32, width of every counter and snapshot (8..48).
- WINDOW_CYCLES, 156250000, clock cycles per measurement window (≥2); default gives 1 s at 156.25 MHz.

Ports:
- clk  in  1  processing clock.
- rst_n  in  1  asynchronous active-low reset.
- stat_rst  in  1  synchronous statistics clear.
- chan_en  in  CHAN_COUNT  per-channel counting enable.
- mon_valid  in  CHAN_COUNT  tvalid of each channel.
- mon_ready  in  CHAN_COUNT  tready of each channel.
- mon_last  in  CHAN_COUNT  tlast of each channel.
- mon_user  in  CHAN_COUNT  tuser (error) of each channel; sampled on the last beat only.
- mon_keep  in  CHAN_COUNT*KEEP_W  tkeep; channel i occupies [i*KEEP_W +: KEEP_W].
- stat_bytes  out  CHAN_COUNT*CNT_W  bytes in last completed window; channel i at [i*CNT_W +: CNT_W].
- stat_frames  out  CHAN_COUNT*CNT_W  frames in last completed window.
- stat_errs  out  CHAN_COUNT*CNT_W  frames with tuser=1 on last beat in last window.
- stat_valid  out  1  one-cycle pulse when snapshots update.
- stat_ovf  out  CHAN_COUNT  sticky: any counter of the channel saturated since last clear.

Behaviour:
- Reset (rst_n=0, asynchronous): timer, all accumulators, all snapshots, stat_valid and stat_ovf go to 0.
- Beat qualification for channel i: beat_i = mon_valid[i] & mon_ready[i] & chan_en[i]. Disabled channels contribute nothing. Snapshots and stat_ovf are held when a channel is disabled.
- Per qualifying beat:
  - byte accumulator += popcount(mon_keep slice); any keep pattern is allowed, including non-contiguous and all-zero.
  - If mon_last[i]: frame accumulator += 1; if also mon_user[i], error accumulator += 1.
- Arithmetic: every accumulator add saturates at 2^CNT_W-1 and never wraps. A saturating add, or an add attempted while already saturated, sets stat_ovf[i].
- Timer counts 0..WINDOW_CYCLES-1 and wraps to 0. The terminal cycle is timer == WINDOW_CYCLES-1.
- On the terminal cycle, for every channel:
  - snapshot <= sat(accumulator + this cycle's contribution); beats on the terminal cycle belong to the closing window.
  - accumulator <= 0.
  - stat_valid <= 1.
  - Snapshots and stat_valid are visible the cycle after the terminal cycle. stat_valid is high for exactly one cycle per window.
- Latency:
  - A beat in cycle t lands in the window containing t.
  - The first snapshot after reset appears WINDOW_CYCLES cycles after rst_n deasserts, with stat_valid high in cycle WINDOW_CYCLES (counting the first post-reset edge as cycle 1).
- stat_rst (synchronous, highest priority after rst_n):
  - Clears accumulators, snapshots, stat_ovf and timer; forces stat_valid to 0.
  - Beats in the same cycle are discarded.
  - If it coincides with the terminal cycle, no snapshot and no stat_valid pulse.
  - The next window starts the following cycle.
- chan_en toggling mid-window: counting stops or starts on that cycle; the window is not restarted.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- CHAN_COUNT=2, WINDOW_CYCLES=16: ch0 sends 3 frames of 2 beats, keep=0xFF then 0x0F, ch1 idle -> at cycle 16 stat_valid=1; ch0 bytes=36, frames=3, errs=0; ch1 all 0; stat_valid low in cycle 17.
- Beat on terminal cycle only (ch0, keep=0x01, last=1, user=1) -> closing snapshot bytes=1, frames=1, errs=1; next window snapshot all 0.
- CNT_W=8: ch1 streams keep=0xFF continuously for 40 beats in one window -> bytes=255, stat_ovf[1]=1; stat_ovf stays 1 through the next window until stat_rst.
- stat_rst asserted on the terminal cycle with traffic present -> no stat_valid pulse; snapshots, stat_ovf and timer 0; next stat_valid 16 cycles after stat_rst deasserts.
- Backpressure: mon_valid=1, mon_ready=0 for 10 cycles, then 2 accepted beats with keep=0xFF -> bytes=16; chan_en=0 for ch0 with full traffic -> ch0 counts 0.
- rst_n pulled low mid-window with nonzero accumulators -> all outputs 0 immediately (asynchronous); counting restarts cleanly after release.
